// File: rtl/dpwm_capture_if.sv
// Bundles the gate-pair inputs and measurement results of dpwm_capture.
// The capture block takes the slave view; the stimulus side takes master.
interface dpwm_capture_if #(
    parameter int WIDTH = 12
);
    logic             enable;
    logic             c1;
    logic             c2;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] ton1;
    logic [WIDTH-1:0] ton2;
    logic [WIDTH-1:0] dt1;
    logic [WIDTH-1:0] dt2;
    logic             meas_valid;
    logic             shoot_thru;
    logic             seq_err;
    logic             timeout;

    modport master (
        output enable, c1, c2,
        input  period, ton1, ton2, dt1, dt2, meas_valid, shoot_thru, seq_err, timeout
    );

    modport slave (
        input  enable, c1, c2,
        output period, ton1, ton2, dt1, dt2, meas_valid, shoot_thru, seq_err, timeout
    );
endinterface

// File: rtl/dpwm_capture.sv
// Receive-side DPWM monitor: measures period, on-times and both dead times
// of a complementary gate pair and flags shoot-through, bad edge order and
// stalled phases. All five results are published together with meas_valid.
module dpwm_capture #(
    parameter int WIDTH       = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              hf_clock,
    input  logic              reset_n,
    dpwm_capture_if.slave     cap
);

    typedef enum logic [2:0] {IDLE, ARM, C1H, DT2, C2H, DT1} state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAX  = '1;

    logic c1s, c2s, c1d, c2d;
    logic c1_rise, c1_fall, c2_rise, c2_fall;
    logic [3:0] edges;

    state_t state, state_next;
    logic [WIDTH-1:0] phase_cnt, phase_next;
    logic [WIDTH-1:0] period_cnt, period_next;
    logic [WIDTH-1:0] ton1_hold, ton1_next;
    logic [WIDTH-1:0] dt2_hold, dt2_next;
    logic [WIDTH-1:0] ton2_hold, ton2_next;
    logic [WIDTH-1:0] res_ton2, res_dt1;
    logic load, bad_edge, set_timeout, shoot, measuring, sat;
    logic enable_d;

    logic [WIDTH-1:0] period_r, ton1_r, ton2_r, dt1_r, dt2_r;
    logic meas_valid_r, shoot_thru_r, seq_err_r, timeout_r;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0] c1_pipe, c2_pipe;

            // Resynchronize the gate pins into the hf_clock domain.
            always_ff @(posedge hf_clock) begin
                if (!reset_n) begin
                    c1_pipe <= '0;
                    c2_pipe <= '0;
                end else begin
                    c1_pipe[0] <= cap.c1;
                    c2_pipe[0] <= cap.c2;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        c1_pipe[i] <= c1_pipe[i-1];
                        c2_pipe[i] <= c2_pipe[i-1];
                    end
                end
            end

            assign c1s = c1_pipe[SYNC_STAGES-1];
            assign c2s = c2_pipe[SYNC_STAGES-1];
        end else begin : g_direct
            assign c1s = cap.c1;
            assign c2s = cap.c2;
        end
    endgenerate

    // One-cycle delayed copies of the synchronized pins for edge detection.
    always_ff @(posedge hf_clock) begin
        if (!reset_n) begin
            c1d      <= 1'b0;
            c2d      <= 1'b0;
            enable_d <= 1'b0;
        end else begin
            c1d      <= c1s;
            c2d      <= c2s;
            enable_d <= cap.enable;
        end
    end

    assign c1_rise   = c1s & ~c1d;
    assign c1_fall   = ~c1s & c1d;
    assign c2_rise   = c2s & ~c2d;
    assign c2_fall   = ~c2s & c2d;
    assign edges     = {c1_rise, c1_fall, c2_rise, c2_fall};
    assign shoot     = cap.enable & c1s & c2s;
    assign measuring = (state == C1H) || (state == DT2) || (state == C2H) || (state == DT1);
    assign sat       = (phase_cnt == MAX) || (period_cnt == MAX);

    // Phase sequencing: each legal edge closes the current phase and the
    // edge cycle itself is counted as the first cycle of the next phase.
    always_comb begin
        state_next  = state;
        phase_next  = phase_cnt + ONE;
        period_next = period_cnt + ONE;
        ton1_next   = ton1_hold;
        dt2_next    = dt2_hold;
        ton2_next   = ton2_hold;
        res_ton2    = ton2_hold;
        res_dt1     = phase_cnt;
        load        = 1'b0;
        bad_edge    = 1'b0;
        set_timeout = 1'b0;
        if (!cap.enable) begin
            state_next  = IDLE;
            phase_next  = ZERO;
            period_next = ZERO;
        end else begin
            case (state)
                IDLE: begin
                    state_next  = ARM;
                    phase_next  = ZERO;
                    period_next = ZERO;
                end
                ARM: begin
                    phase_next  = ZERO;
                    period_next = ZERO;
                    if (c1_rise && !shoot) begin
                        state_next  = C1H;
                        phase_next  = ONE;
                        period_next = ONE;
                    end
                end
                C1H: begin
                    if (edges == 4'b0100) begin
                        state_next = DT2;
                        ton1_next  = phase_cnt;
                        phase_next = ONE;
                    end else if (edges == 4'b0110) begin
                        state_next = C2H;
                        ton1_next  = phase_cnt;
                        dt2_next   = ZERO;
                        phase_next = ONE;
                    end else if (edges != 4'b0000) begin
                        bad_edge = 1'b1;
                    end
                end
                DT2: begin
                    if (edges == 4'b0010) begin
                        state_next = C2H;
                        dt2_next   = phase_cnt;
                        phase_next = ONE;
                    end else if (edges != 4'b0000) begin
                        bad_edge = 1'b1;
                    end
                end
                C2H: begin
                    if (edges == 4'b0001) begin
                        state_next = DT1;
                        ton2_next  = phase_cnt;
                        phase_next = ONE;
                    end else if (edges == 4'b1001) begin
                        state_next  = C1H;
                        load        = 1'b1;
                        res_ton2    = phase_cnt;
                        res_dt1     = ZERO;
                        phase_next  = ONE;
                        period_next = ONE;
                    end else if (edges != 4'b0000) begin
                        bad_edge = 1'b1;
                    end
                end
                DT1: begin
                    if (edges == 4'b1000) begin
                        state_next  = C1H;
                        load        = 1'b1;
                        res_ton2    = ton2_hold;
                        res_dt1     = phase_cnt;
                        phase_next  = ONE;
                        period_next = ONE;
                    end else if (edges != 4'b0000) begin
                        bad_edge = 1'b1;
                    end
                end
                default: begin
                    state_next  = IDLE;
                    phase_next  = ZERO;
                    period_next = ZERO;
                end
            endcase
            if (measuring) begin
                set_timeout = sat;
                if (shoot || bad_edge || sat) begin
                    state_next  = ARM;
                    phase_next  = ZERO;
                    period_next = ZERO;
                    load        = 1'b0;
                end
            end
        end
    end

    // State, running counters and intermediate phase results.
    always_ff @(posedge hf_clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            phase_cnt  <= ZERO;
            period_cnt <= ZERO;
            ton1_hold  <= ZERO;
            dt2_hold   <= ZERO;
            ton2_hold  <= ZERO;
        end else begin
            state      <= state_next;
            phase_cnt  <= phase_next;
            period_cnt <= period_next;
            ton1_hold  <= ton1_next;
            dt2_hold   <= dt2_next;
            ton2_hold  <= ton2_next;
        end
    end

    // Publish a complete period's results together, one cycle after closure.
    always_ff @(posedge hf_clock) begin
        if (!reset_n) begin
            meas_valid_r <= 1'b0;
            period_r     <= ZERO;
            ton1_r       <= ZERO;
            dt2_r        <= ZERO;
            ton2_r       <= ZERO;
            dt1_r        <= ZERO;
        end else begin
            meas_valid_r <= load;
            if (load) begin
                period_r <= period_cnt;
                ton1_r   <= ton1_hold;
                dt2_r    <= dt2_hold;
                ton2_r   <= res_ton2;
                dt1_r    <= res_dt1;
            end
        end
    end

    // Sticky fault flags, cleared when capture is switched off.
    always_ff @(posedge hf_clock) begin
        if (!reset_n) begin
            shoot_thru_r <= 1'b0;
            seq_err_r    <= 1'b0;
            timeout_r    <= 1'b0;
        end else if (enable_d && !cap.enable) begin
            shoot_thru_r <= 1'b0;
            seq_err_r    <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            shoot_thru_r <= shoot_thru_r | shoot;
            seq_err_r    <= seq_err_r | bad_edge;
            timeout_r    <= timeout_r | set_timeout;
        end
    end

    assign cap.period     = period_r;
    assign cap.ton1       = ton1_r;
    assign cap.ton2       = ton2_r;
    assign cap.dt1        = dt1_r;
    assign cap.dt2        = dt2_r;
    assign cap.meas_valid = meas_valid_r;
    assign cap.shoot_thru = shoot_thru_r;
    assign cap.seq_err    = seq_err_r;
    assign cap.timeout    = timeout_r;

endmodule

// File: tb/tb_dpwm_capture.sv
// Directed bench for dpwm_capture: a table of gate patterns with
// hand-computed results, followed by fault and reset sequences.
module tb_dpwm_capture;

    logic hf_clock = 1'b0;
    logic reset_n  = 1'b0;
    int   checks   = 0;
    int   errors   = 0;
    int   valid_count = 0;
    int   snap;

    dpwm_capture_if #(.WIDTH(12)) cap ();

    dpwm_capture #(.WIDTH(12), .SYNC_STAGES(2)) dut (
        .hf_clock (hf_clock),
        .reset_n  (reset_n),
        .cap      (cap)
    );

    always #5 hf_clock = ~hf_clock;

    // Count result pulses, sampled away from the active edge.
    always @(negedge hf_clock) begin
        if (cap.meas_valid === 1'b1) valid_count++;
    end

    typedef struct {
        int t1; int d2; int t2; int d1;
        int e_period; int e_ton1; int e_dt2; int e_ton2; int e_dt1;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Hold the pins for n clock edges; returns just after an active edge.
    task automatic setPins(input logic v1, input logic v2, input int n);
        cap.c1 = v1;
        cap.c2 = v2;
        repeat (n) @(posedge hf_clock);
        #1;
    endtask

    task automatic applyStimulus(input int t1, input int d2, input int t2, input int d1);
        setPins(1'b1, 1'b0, t1);
        if (d2 > 0) setPins(1'b0, 1'b0, d2);
        setPins(1'b0, 1'b1, t2);
        if (d1 > 0) setPins(1'b0, 1'b0, d1);
    endtask

    initial begin
        vecs[0] = '{40, 5, 50, 5, 100, 40, 5, 50, 5};
        vecs[1] = '{40, 0, 55, 5, 100, 40, 0, 55, 5};
        vecs[2] = '{30, 5, 60, 0, 95, 30, 5, 60, 0};
        vecs[3] = '{90, 10, 90, 10, 200, 90, 10, 90, 10};
        vecs[4] = '{1, 1, 1, 1, 4, 1, 1, 1, 1};
        vecs[5] = '{3, 2, 7, 4, 16, 3, 2, 7, 4};

        cap.enable = 1'b0;
        cap.c1 = 1'b0;
        cap.c2 = 1'b0;
        reset_n = 1'b0;
        repeat (4) @(posedge hf_clock);
        #1;
        checkOutput("reset period", int'(cap.period), 0);
        checkOutput("reset ton1", int'(cap.ton1), 0);
        checkOutput("reset ton2", int'(cap.ton2), 0);
        checkOutput("reset dt1", int'(cap.dt1), 0);
        checkOutput("reset dt2", int'(cap.dt2), 0);
        checkOutput("reset meas_valid", int'(cap.meas_valid), 0);
        checkOutput("reset shoot_thru", int'(cap.shoot_thru), 0);
        checkOutput("reset seq_err", int'(cap.seq_err), 0);
        checkOutput("reset timeout", int'(cap.timeout), 0);

        reset_n = 1'b1;
        cap.enable = 1'b1;
        setPins(1'b0, 1'b0, 4);

        // Each pattern is driven for two periods; the second period's
        // opening rise publishes the first period's measurement.
        for (int i = 0; i < 6; i++) begin
            snap = valid_count;
            applyStimulus(vecs[i].t1, vecs[i].d2, vecs[i].t2, vecs[i].d1);
            applyStimulus(vecs[i].t1, vecs[i].d2, vecs[i].t2, vecs[i].d1);
            checkOutput($sformatf("vec%0d period", i), int'(cap.period), vecs[i].e_period);
            checkOutput($sformatf("vec%0d ton1", i), int'(cap.ton1), vecs[i].e_ton1);
            checkOutput($sformatf("vec%0d dt2", i), int'(cap.dt2), vecs[i].e_dt2);
            checkOutput($sformatf("vec%0d ton2", i), int'(cap.ton2), vecs[i].e_ton2);
            checkOutput($sformatf("vec%0d dt1", i), int'(cap.dt1), vecs[i].e_dt1);
            checkOutput($sformatf("vec%0d valid pulses", i), valid_count - snap, (i == 0) ? 1 : 2);
            checkOutput($sformatf("vec%0d seq_err", i), int'(cap.seq_err), 0);
            checkOutput($sformatf("vec%0d shoot_thru", i), int'(cap.shoot_thru), 0);
        end

        // Shoot-through glitch in the middle of the c2 on-time.
        setPins(1'b1, 1'b0, 40);
        setPins(1'b0, 1'b0, 5);
        setPins(1'b0, 1'b1, 20);
        setPins(1'b1, 1'b1, 1);
        setPins(1'b0, 1'b1, 29);
        setPins(1'b0, 1'b0, 5);
        checkOutput("shoot flag set", int'(cap.shoot_thru), 1);
        snap = valid_count;
        applyStimulus(40, 5, 50, 5);
        checkOutput("shoot no valid during rearm", valid_count - snap, 0);
        setPins(1'b1, 1'b0, 10);
        checkOutput("shoot valid resumes", valid_count - snap, 1);
        checkOutput("shoot resumed period", int'(cap.period), 100);
        checkOutput("shoot flag sticky", int'(cap.shoot_thru), 1);

        // Disable clears the sticky flags but holds the last results.
        cap.enable = 1'b0;
        setPins(1'b0, 1'b0, 5);
        checkOutput("disable clears shoot", int'(cap.shoot_thru), 0);
        checkOutput("disable meas_valid", int'(cap.meas_valid), 0);
        checkOutput("disable holds period", int'(cap.period), 100);
        checkOutput("disable holds ton1", int'(cap.ton1), 40);

        // c2 rises while still in the c1 on-time.
        cap.enable = 1'b1;
        setPins(1'b0, 1'b0, 3);
        setPins(1'b1, 1'b0, 10);
        setPins(1'b1, 1'b1, 3);
        setPins(1'b0, 1'b0, 5);
        checkOutput("c2 rise in C1H seq_err", int'(cap.seq_err), 1);
        cap.enable = 1'b0;
        setPins(1'b0, 1'b0, 3);
        checkOutput("seq_err cleared", int'(cap.seq_err), 0);

        // c1 rises again during dead time 2.
        cap.enable = 1'b1;
        setPins(1'b0, 1'b0, 3);
        setPins(1'b1, 1'b0, 10);
        setPins(1'b0, 1'b0, 3);
        setPins(1'b1, 1'b0, 5);
        setPins(1'b0, 1'b0, 3);
        checkOutput("c1 rise in DT2 seq_err", int'(cap.seq_err), 1);
        checkOutput("c1 rise in DT2 no shoot", int'(cap.shoot_thru), 0);
        cap.enable = 1'b0;
        setPins(1'b0, 1'b0, 3);

        // One c1 pulse then silence: timeout only once the counter saturates.
        cap.enable = 1'b1;
        setPins(1'b0, 1'b0, 3);
        snap = valid_count;
        setPins(1'b1, 1'b0, 10);
        setPins(1'b0, 1'b0, 4080);
        checkOutput("timeout not yet", int'(cap.timeout), 0);
        setPins(1'b0, 1'b0, 10);
        checkOutput("timeout set", int'(cap.timeout), 1);
        checkOutput("timeout no valid", valid_count - snap, 0);
        cap.enable = 1'b0;
        setPins(1'b0, 1'b0, 3);
        checkOutput("timeout cleared", int'(cap.timeout), 0);

        // Reset in the middle of the c2 on-time.
        cap.enable = 1'b1;
        setPins(1'b0, 1'b0, 3);
        applyStimulus(40, 5, 50, 5);
        applyStimulus(40, 5, 50, 5);
        setPins(1'b1, 1'b0, 40);
        setPins(1'b0, 1'b0, 5);
        setPins(1'b0, 1'b1, 20);
        reset_n = 1'b0;
        @(posedge hf_clock);
        #1;
        reset_n = 1'b1;
        checkOutput("midreset period", int'(cap.period), 0);
        checkOutput("midreset ton1", int'(cap.ton1), 0);
        checkOutput("midreset ton2", int'(cap.ton2), 0);
        checkOutput("midreset dt1", int'(cap.dt1), 0);
        checkOutput("midreset dt2", int'(cap.dt2), 0);
        checkOutput("midreset meas_valid", int'(cap.meas_valid), 0);
        setPins(1'b0, 1'b1, 29);
        setPins(1'b0, 1'b0, 5);
        snap = valid_count;
        applyStimulus(40, 5, 50, 5);
        checkOutput("midreset no early valid", valid_count - snap, 0);
        setPins(1'b1, 1'b0, 10);
        checkOutput("midreset valid after period", valid_count - snap, 1);
        checkOutput("midreset new period", int'(cap.period), 100);
        checkOutput("midreset new ton2", int'(cap.ton2), 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
